processor_pio_out_ctrl: RTL and testbench
=========================================

# processor_pio_out_ctrl

Parametrised Avalon-MM slave output port: a DATA_W-bit output register driven by the processor through DATA, SET, CLEAR and TOGGLE registers. Per-bit pulse mode makes selected bits auto-clear after a programmable cycle count. A one-cycle change strobe accompanies every update of the output. It sits on the processor's Avalon-MM bus and drives strobe/enable lines into the 3D engine datapath, such as buffer write enables.

## Interface
- DATA_W, 8: output width, 1..32
- CNT_W, 16: pulse counter width, 1..32
- RESET_VALUE, 0: out_port value after reset, DATA_W bits
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- address  in  3  register word offset
- chipselect  in  1  slave select
- write_n  in  1  active-low write
- writedata  in  32  write data
- readdata  out  32  read data, zero-extended
- out_port  out  DATA_W  output register
- out_changed  out  1  one-cycle strobe, high in the first cycle out_port shows a new value
- pulse_busy  out  1  pulse timer running

## Operation
- Write: chipselect && !write_n. Reads are side-effect free.
- Register map:
  - 0 DATA: R/W; write loads writedata[DATA_W-1:0]
  - 1 MODE: R/W; bit=1 puts that out_port bit in pulse mode
  - 2 SET: W; out_port |= wd; reads 0
  - 3 CLEAR: W; out_port &= ~wd; reads 0
  - 4 TOGGLE: W; out_port ^= wd; reads 0
  - 5 PULSE_LEN: R/W; CNT_W bits
  - 6 STATUS: RO; bit0 = pulse_busy
  - 7: reads 0, writes ignored
- Unused upper writedata bits are ignored. Unused upper readdata bits read 0.
- Trigger: a write to DATA, SET or TOGGLE whose resulting value has (next & MODE) != 0.
  - Loads counter with max(PULSE_LEN, 1).
  - A trigger while busy reloads the counter (retrigger).
- Counter behaviour:
  - While counter != 0 it decrements by 1 each cycle.
  - On the cycle it decrements from 1 to 0, out_port &= ~MODE, using the MODE value current at that cycle.
  - pulse_busy = (counter != 0).
- Pulse-mode bits are therefore high for exactly max(PULSE_LEN,1) cycles.
- Simultaneous expiry and bus write to 0/2/3/4:
  - The write is applied to the pre-expiry value.
  - If the write triggers, expiry clearing is suppressed and the counter reloads.
  - Otherwise the expiry clear is applied after the write.
- CLEAR never triggers. Clearing all pulse-mode bits does not stop the counter; expiry is then harmless.
- Writing MODE or PULSE_LEN while busy does not restart the counter.
- out_changed is registered: it is high in the cycle after any edge where out_port's next value != current value. Causes are a write or an expiry.

## Timing
- Read latency 0: readdata is combinational from address and registers.
- Write effect visible on out_port the cycle after the write edge; out_changed is high in that same cycle.
- Pulse starting with the out_port rise at cycle T ends with out_port low at cycle T+max(PULSE_LEN,1).
- Reset values:
  - out_port = RESET_VALUE
  - MODE = 0
  - PULSE_LEN = 1
  - counter = 0
  - out_changed = 0
  - pulse_busy = 0
- Reset asserted mid-pulse aborts the pulse at the next edge; no out_changed is emitted for the reset.

## Structure
- Shared package processor_pio_pkg: register offset constants (ADDR_DATA..ADDR_STATUS) and the STATUS bit index.
- Sub-module processor_pio_pulse_timer. It takes load, load_value and clk/reset, and outputs busy and expire, where expire is a one-cycle pulse on the 1->0 decrement.
- Top level holds the register file, next-value mux, priority logic and the out_changed register.

## Test plan
- Reset with RESET_VALUE=8'hA5 -> out_port=A5, out_changed=0, STATUS=0, PULSE_LEN reads 1.
- Write DATA=3C, then SET=C3, then CLEAR=0F, then TOGGLE=FF -> out_port 3C, FF, F0, 0F, with a one-cycle out_changed after each. A second identical CLEAR gives no strobe.
- MODE=01, PULSE_LEN=4, SET=01 -> bit0 high exactly 4 cycles, pulse_busy high 4 cycles, out_changed on both rise and fall.
- Same setup; retrigger with SET=01 at cycle 2 of the pulse -> bit0 stays high for 6 cycles total, with a single rise and a single fall.
- PULSE_LEN=0 -> 1-cycle pulse. Write DATA=00 on the expiry cycle -> no trigger, out_port=00, no double strobe. Assert reset mid-pulse -> busy=0 next cycle.
- Read offsets 2,3,4,7 -> 0. Write to offset 7 -> no state change. With DATA_W=32 and CNT_W=32, write DATA=FFFFFFFF -> full width reads back.

Source files
------------

// File: rtl/processor_pio_pkg.sv
// processor_pio_pkg
// Shared constants for the processor PIO output port.
//   - Register word offsets on the Avalon-MM slave (ADDR_DATA .. ADDR_STATUS).
//   - Bit position of the busy flag inside the STATUS register.
package processor_pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_MODE      = 3'd1;
  localparam logic [2:0] ADDR_SET       = 3'd2;
  localparam logic [2:0] ADDR_CLEAR     = 3'd3;
  localparam logic [2:0] ADDR_TOGGLE    = 3'd4;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd5;
  localparam logic [2:0] ADDR_STATUS    = 3'd6;

  localparam int STATUS_BUSY_BIT = 0;

endpackage

// File: rtl/processor_pio_out_ctrl_if.sv
// processor_pio_out_ctrl_if
// Avalon-MM slave bus bundle for the PIO output port.
//   address    : register word offset
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : read data (combinational, zero-extended)
// Modports: master (processor side), slave (PIO side).
interface processor_pio_out_ctrl_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/processor_pio_pulse_timer.sv
// processor_pio_pulse_timer
// Down-counter that times pulse-mode bits.
//   clk, reset : clock and synchronous active-high reset
//   load       : (re)load the counter with load_value
//   load_value : count to load, caller guarantees it is non-zero
//   busy       : counter is non-zero
//   expire     : one-cycle pulse in the cycle the counter steps 1 -> 0
module processor_pio_pulse_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             busy,
  output logic             expire
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign busy   = (count_q != '0);
  // A reload in the final cycle wins, so the 1 -> 0 step never happens.
  assign expire = !load && (count_q == CNT_W'(1));

endmodule

// File: rtl/processor_pio_out_ctrl.sv
// processor_pio_out_ctrl
// Avalon-MM slave output port with DATA/SET/CLEAR/TOGGLE access, per-bit
// pulse mode with a programmable length and a one-cycle change strobe.
//   clk, reset  : clock and synchronous active-high reset
//   bus         : Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   out_port    : DATA_W-bit output register
//   out_changed : high in the first cycle out_port shows a new value
//   pulse_busy  : pulse timer running
module processor_pio_out_ctrl
  import processor_pio_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                CNT_W       = 16,
  parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  processor_pio_out_ctrl_if.slave  bus,
  output logic [DATA_W-1:0]        out_port,
  output logic                     out_changed,
  output logic                     pulse_busy
);

  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] mode_q, mode_d;
  logic [CNT_W-1:0]  plen_q, plen_d;
  logic              changed_q, changed_d;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] wr_val;
  logic [CNT_W-1:0]  load_value;
  logic              wr_en;
  logic              trigger;
  logic              expire;
  logic              busy;
  logic [31:0]       rdata;
  logic              unused_wd;

  assign wr_en     = bus.chipselect && !bus.write_n;
  assign wd        = bus.writedata[DATA_W-1:0];
  assign unused_wd = ^bus.writedata;

  // Per-bit value after applying this cycle's bus write (if any).
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
      assign wr_val[gi] =
          !wr_en                       ? data_q[gi] :
          (bus.address == ADDR_DATA)   ? wd[gi] :
          (bus.address == ADDR_SET)    ? (data_q[gi] | wd[gi]) :
          (bus.address == ADDR_CLEAR)  ? (data_q[gi] & ~wd[gi]) :
          (bus.address == ADDR_TOGGLE) ? (data_q[gi] ^ wd[gi]) :
                                         data_q[gi];
      // Expiry clears pulse-mode bits after the write, unless the write retriggers.
      assign data_d[gi] = wr_val[gi] & ~(expire && !trigger && mode_q[gi]);
    end
  endgenerate

  // CLEAR is deliberately absent: it can only lower bits.
  assign trigger = wr_en &&
                   ((bus.address == ADDR_DATA) || (bus.address == ADDR_SET) ||
                    (bus.address == ADDR_TOGGLE)) &&
                   ((wr_val & mode_q) != '0);

  assign load_value = (plen_q == '0) ? CNT_W'(1) : plen_q;

  processor_pio_pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (trigger),
    .load_value (load_value),
    .busy       (busy),
    .expire     (expire)
  );

  always_comb begin
    mode_d = mode_q;
    plen_d = plen_q;
    if (wr_en && (bus.address == ADDR_MODE))      mode_d = wd;
    if (wr_en && (bus.address == ADDR_PULSE_LEN)) plen_d = bus.writedata[CNT_W-1:0];
  end

  assign changed_d = (data_d != data_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= RESET_VALUE;
      mode_q    <= '0;
      plen_q    <= CNT_W'(1);
      changed_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      mode_q    <= mode_d;
      plen_q    <= plen_d;
      changed_q <= changed_d;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (bus.address)
      ADDR_DATA:      rdata = 32'(data_q);
      ADDR_MODE:      rdata = 32'(mode_q);
      ADDR_PULSE_LEN: rdata = 32'(plen_q);
      ADDR_STATUS:    rdata[STATUS_BUSY_BIT] = busy;
      default:        rdata = '0;
    endcase
  end

  assign bus.readdata = rdata;
  assign out_port     = data_q;
  assign out_changed  = changed_q;
  assign pulse_busy   = busy;

endmodule

// File: tb/tb_processor_pio_out_ctrl.sv
// tb_processor_pio_out_ctrl
// Directed bench: DUT A (8-bit, RESET_VALUE=A5) covers register access,
// pulse timing, retrigger, expiry/write collisions and reset; DUT B
// (32-bit data, 32-bit counter) covers full-width readback.
module tb_processor_pio_out_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [7:0]  out_a;
  logic        chg_a, busy_a;
  logic [31:0] out_b;
  logic        chg_b, busy_b;
  logic [31:0] rv;

  processor_pio_out_ctrl_if bus_a ();
  processor_pio_out_ctrl_if bus_b ();

  processor_pio_out_ctrl #(.DATA_W(8), .CNT_W(16), .RESET_VALUE(8'hA5)) dut_a (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_a.slave),
    .out_port    (out_a),
    .out_changed (chg_a),
    .pulse_busy  (busy_a)
  );

  processor_pio_out_ctrl #(.DATA_W(32), .CNT_W(32), .RESET_VALUE(32'h0)) dut_b (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_b.slave),
    .out_port    (out_b),
    .out_changed (chg_b),
    .pulse_busy  (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [7:0] o, input logic c, input logic b);
    chk({tag, ".out"}, 64'(out_a), 64'(o));
    chk({tag, ".chg"}, 64'(chg_a), 64'(c));
    chk({tag, ".busy"}, 64'(busy_a), 64'(b));
    $display("step %-14s out=%h chg=%b busy=%b", tag, out_a, chg_a, busy_a);
  endtask

  task automatic idle();
    bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.address = '0; bus_a.writedata = '0;
    bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.address = '0; bus_b.writedata = '0;
  endtask

  // Called at a negedge; returns at the next negedge, after the write edge.
  task automatic wr(input bit b, input logic [2:0] a, input logic [31:0] d);
    if (b) begin
      bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0; bus_b.address = a; bus_b.writedata = d;
    end else begin
      bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0; bus_a.address = a; bus_a.writedata = d;
    end
    @(negedge clk);
    idle();
  endtask

  task automatic rd(input bit b, input logic [2:0] a, output logic [31:0] v);
    if (b) begin
      bus_b.chipselect = 1'b1; bus_b.write_n = 1'b1; bus_b.address = a;
    end else begin
      bus_a.chipselect = 1'b1; bus_a.write_n = 1'b1; bus_a.address = a;
    end
    #1;
    v = b ? bus_b.readdata : bus_a.readdata;
    $display("read  dut=%0d addr=%0d data=%h", b, a, v);
    idle();
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk_a("reset", 8'hA5, 1'b0, 1'b0);
    rd(0, 3'd6, rv); chk("reset.status", 64'(rv), 64'h0);
    rd(0, 3'd5, rv); chk("reset.plen", 64'(rv), 64'h1);
    rd(0, 3'd1, rv); chk("reset.mode", 64'(rv), 64'h0);

    // DATA / SET / CLEAR / TOGGLE
    wr(0, 3'd0, 32'h0000_003C); chk_a("data3C", 8'h3C, 1'b1, 1'b0);
    tick();                     chk_a("data3C.idle", 8'h3C, 1'b0, 1'b0);
    wr(0, 3'd2, 32'hFFFF_FFC3); chk_a("setC3", 8'hFF, 1'b1, 1'b0);
    tick();                     chk_a("setC3.idle", 8'hFF, 1'b0, 1'b0);
    wr(0, 3'd3, 32'h0000_000F); chk_a("clr0F", 8'hF0, 1'b1, 1'b0);
    tick();                     chk_a("clr0F.idle", 8'hF0, 1'b0, 1'b0);
    wr(0, 3'd3, 32'h0000_000F); chk_a("clr0F.again", 8'hF0, 1'b0, 1'b0);
    wr(0, 3'd4, 32'h0000_00FF); chk_a("tglFF", 8'h0F, 1'b1, 1'b0);
    tick();                     chk_a("tglFF.idle", 8'h0F, 1'b0, 1'b0);
    rd(0, 3'd0, rv); chk("rd.data", 64'(rv), 64'h0F);

    // Basic 4-cycle pulse on bit0
    wr(0, 3'd0, 32'h0);
    wr(0, 3'd1, 32'h1);
    wr(0, 3'd5, 32'h4);
    rd(0, 3'd1, rv); chk("rd.mode", 64'(rv), 64'h01);
    rd(0, 3'd5, rv); chk("rd.plen", 64'(rv), 64'h4);
    wr(0, 3'd2, 32'h1);         chk_a("p4.rise", 8'h01, 1'b1, 1'b1);
    rd(0, 3'd6, rv); chk("p4.status", 64'(rv), 64'h1);
    tick();                     chk_a("p4.c1", 8'h01, 1'b0, 1'b1);
    tick();                     chk_a("p4.c2", 8'h01, 1'b0, 1'b1);
    tick();                     chk_a("p4.c3", 8'h01, 1'b0, 1'b1);
    tick();                     chk_a("p4.fall", 8'h00, 1'b1, 1'b0);
    tick();                     chk_a("p4.after", 8'h00, 1'b0, 1'b0);

    // Retrigger at cycle 2 of the pulse: high 6 cycles in total
    wr(0, 3'd2, 32'h1);         chk_a("rt.rise", 8'h01, 1'b1, 1'b1);
    tick();                     chk_a("rt.c1", 8'h01, 1'b0, 1'b1);
    wr(0, 3'd2, 32'h1);         chk_a("rt.c2", 8'h01, 1'b0, 1'b1);
    tick();                     chk_a("rt.c3", 8'h01, 1'b0, 1'b1);
    tick();                     chk_a("rt.c4", 8'h01, 1'b0, 1'b1);
    tick();                     chk_a("rt.c5", 8'h01, 1'b0, 1'b1);
    tick();                     chk_a("rt.fall", 8'h00, 1'b1, 1'b0);
    tick();                     chk_a("rt.after", 8'h00, 1'b0, 1'b0);

    // PULSE_LEN=0 behaves as 1
    wr(0, 3'd5, 32'h0);
    wr(0, 3'd2, 32'h1);         chk_a("p0.rise", 8'h01, 1'b1, 1'b1);
    tick();                     chk_a("p0.fall", 8'h00, 1'b1, 1'b0);
    tick();                     chk_a("p0.after", 8'h00, 1'b0, 1'b0);

    // DATA=00 on the expiry cycle: no trigger, single strobe
    wr(0, 3'd2, 32'h1);         chk_a("ex.rise", 8'h01, 1'b1, 1'b1);
    wr(0, 3'd0, 32'h0);         chk_a("ex.data00", 8'h00, 1'b1, 1'b0);
    tick();                     chk_a("ex.after", 8'h00, 1'b0, 1'b0);

    // SET on the expiry cycle retriggers and suppresses the clear
    wr(0, 3'd2, 32'h1);         chk_a("exrt.rise", 8'h01, 1'b1, 1'b1);
    wr(0, 3'd2, 32'h1);         chk_a("exrt.hold", 8'h01, 1'b0, 1'b1);
    tick();                     chk_a("exrt.fall", 8'h00, 1'b1, 1'b0);

    // Reset mid-pulse
    wr(0, 3'd5, 32'h4);
    wr(0, 3'd2, 32'h1);         chk_a("rs.rise", 8'h01, 1'b1, 1'b1);
    tick();                     chk_a("rs.c1", 8'h01, 1'b0, 1'b1);
    reset = 1'b1;
    tick();                     chk_a("rs.reset", 8'hA5, 1'b0, 1'b0);
    reset = 1'b0;
    tick();                     chk_a("rs.after", 8'hA5, 1'b0, 1'b0);

    // Write-only and unused offsets read 0; offset 7 writes are ignored
    rd(0, 3'd2, rv); chk("rd.set", 64'(rv), 64'h0);
    rd(0, 3'd3, rv); chk("rd.clear", 64'(rv), 64'h0);
    rd(0, 3'd4, rv); chk("rd.toggle", 64'(rv), 64'h0);
    rd(0, 3'd7, rv); chk("rd.off7", 64'(rv), 64'h0);
    wr(0, 3'd7, 32'hFFFF_FFFF); chk_a("wr7", 8'hA5, 1'b0, 1'b0);
    rd(0, 3'd1, rv); chk("wr7.mode", 64'(rv), 64'h0);
    rd(0, 3'd5, rv); chk("wr7.plen", 64'(rv), 64'h1);

    // Full-width instance
    chk("b.reset", 64'(out_b), 64'h0);
    wr(1, 3'd0, 32'hFFFF_FFFF);
    chk("b.out", 64'(out_b), 64'hFFFF_FFFF);
    chk("b.chg", 64'(chg_b), 64'h1);
    rd(1, 3'd0, rv); chk("b.rd.data", 64'(rv), 64'hFFFF_FFFF);
    wr(1, 3'd5, 32'hFFFF_FFFF);
    rd(1, 3'd5, rv); chk("b.rd.plen", 64'(rv), 64'hFFFF_FFFF);
    wr(1, 3'd1, 32'h8000_0001);
    rd(1, 3'd1, rv); chk("b.rd.mode", 64'(rv), 64'h8000_0001);
    chk("b.busy", 64'(busy_b), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
